// File: rtl/Uop.sv
// Uop: shared micro-op types for the register file and its clients.
package Uop;
  localparam int XLEN = 32;
  localparam int REG_W = 5;
  localparam int SB_CNT_W = 2;
  typedef logic [REG_W-1:0] reg_t;
  typedef logic [XLEN-1:0] val_t;
  typedef logic [SB_CNT_W-1:0] sb_cnt_t;
  localparam reg_t REG_ZERO = '0;
endpackage

// File: rtl/regfile_write_if.sv
// regfile_write_if: write-back commit port into the register file.
interface regfile_write_if;
  import Uop::*;
  logic en;
  reg_t addr;
  val_t val;
  modport Server (input en, addr, val);
  modport Client (output en, addr, val);
endinterface

// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard: per-register pending-write counters for RAW hazard detection.
module regfile_scoreboard
  import Uop::*;
#(
  parameter int NUM_REGS = 32,
  parameter int NUM_READ = 2,
  parameter int CNT_W = SB_CNT_W
) (
  input  logic clk,
  input  logic rst_n,
  input  logic issue_en,
  input  reg_t issue_rd,
  input  logic wr_en,
  input  reg_t wr_addr,
  input  logic flush,
  input  reg_t [NUM_READ-1:0] rd_addr,
  output logic issue_ready,
  output logic [NUM_READ-1:0] busy_nxt
);
  logic [CNT_W-1:0] cnt [NUM_REGS];
  logic [CNT_W-1:0] cnt_nxt [NUM_REGS];
  // a same-cycle decrement is deliberately not credited toward readiness
  assign issue_ready = issue_rd == REG_ZERO || cnt[issue_rd] != '1;
  always_comb begin
    for (int r = 0; r < NUM_REGS; r++)
      cnt_nxt[r] = (flush || r == 0) ? '0 :
        cnt[r] + CNT_W'(issue_en && issue_ready && issue_rd == reg_t'(r))
               - CNT_W'(wr_en && wr_addr == reg_t'(r) && cnt[r] != '0);
    for (int i = 0; i < NUM_READ; i++)
      busy_nxt[i] = cnt_nxt[rd_addr[i]] != '0;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n)
      for (int r = 0; r < NUM_REGS; r++) cnt[r] <= '0;
    else
      cnt <= cnt_nxt;
endmodule

// File: rtl/register_file.sv
// register_file: architectural registers with synchronous read ports,
// write-first forwarding and a pending-write scoreboard.
module register_file
  import Uop::*;
#(
  parameter int NUM_REGS = 32,
  parameter int NUM_READ = 2,
  parameter int CNT_W = SB_CNT_W
) (
  input  logic clk,
  input  logic rst_n,
  regfile_write_if.Server write0,
  input  logic [NUM_READ-1:0] rdEn,
  input  reg_t [NUM_READ-1:0] rdAddr,
  output val_t [NUM_READ-1:0] rdVal,
  output logic [NUM_READ-1:0] rdBusy,
  input  logic issueEn,
  input  reg_t issueRd,
  output logic issueReady,
  input  logic flush
);
  val_t mem [NUM_REGS];
  logic [NUM_READ-1:0] busy_nxt;
  logic we;
  assign we = write0.en && write0.addr != REG_ZERO;
  regfile_scoreboard #(.NUM_REGS(NUM_REGS), .NUM_READ(NUM_READ), .CNT_W(CNT_W)) u_sb (
    .clk(clk),
    .rst_n(rst_n),
    .issue_en(issueEn),
    .issue_rd(issueRd),
    .wr_en(write0.en),
    .wr_addr(write0.addr),
    .flush(flush),
    .rd_addr(rdAddr),
    .issue_ready(issueReady),
    .busy_nxt(busy_nxt)
  );
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      for (int r = 0; r < NUM_REGS; r++) mem[r] <= '0;
      rdVal <= '0;
      rdBusy <= '0;
    end else begin
      if (we) mem[write0.addr] <= write0.val;
      for (int i = 0; i < NUM_READ; i++)
        if (rdEn[i]) begin
          rdVal[i] <= rdAddr[i] == REG_ZERO ? '0 :
                      (we && write0.addr == rdAddr[i]) ? write0.val : mem[rdAddr[i]];
          rdBusy[i] <= busy_nxt[i];
        end
    end
endmodule

// File: tb/tb_register_file.sv
// tb_register_file: randomized + directed scoreboard bench against an array/queue reference model.
module tb_register_file;
  import Uop::*;
  localparam int CMAX = 3;
  logic clk = 0;
  logic rst_n = 0;
  always #5 clk = ~clk;
  regfile_write_if wif();
  logic [1:0] rdEn;
  reg_t [1:0] rdAddr;
  val_t [1:0] rdVal;
  logic [1:0] rdBusy;
  logic issueEn;
  reg_t issueRd;
  logic issueReady;
  logic flush;
  register_file #(.NUM_REGS(32), .NUM_READ(2), .CNT_W(2)) dut (
    .clk(clk), .rst_n(rst_n), .write0(wif), .rdEn(rdEn), .rdAddr(rdAddr),
    .rdVal(rdVal), .rdBusy(rdBusy), .issueEn(issueEn), .issueRd(issueRd),
    .issueReady(issueReady), .flush(flush)
  );
  typedef struct { val_t v; logic b; } rd_t;
  int n_checks = 0;
  int n_fail = 0;
  val_t mem_m [32];
  int cnt_m [32];
  rd_t q [2][$];
  rd_t last [2];
  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask
  task automatic clear_model();
    for (int r = 0; r < 32; r++) begin mem_m[r] = '0; cnt_m[r] = 0; end
    for (int p = 0; p < 2; p++) begin q[p].delete(); last[p].v = '0; last[p].b = 1'b0; end
  endtask
  // Drive one cycle of stimulus, then predict what the coming edge must produce.
  task automatic drive(bit ie, int ird, bit we, int wa, val_t wv, bit fl, bit [1:0] re, int a0, int a1);
    bit rdy;
    int nc [32];
    int a;
    rd_t e;
    @(negedge clk);
    issueEn = ie; issueRd = reg_t'(ird);
    wif.en = we; wif.addr = reg_t'(wa); wif.val = wv;
    flush = fl; rdEn = re; rdAddr[0] = reg_t'(a0); rdAddr[1] = reg_t'(a1);
    #1;
    rdy = ird == 0 || cnt_m[ird] < CMAX;
    chk($sformatf("issueReady r%0d", ird), 32'(issueReady), 32'(rdy));
    nc = cnt_m;
    if (fl) for (int r = 0; r < 32; r++) nc[r] = 0;
    else begin
      if (ie && rdy && ird != 0) nc[ird]++;
      if (we && wa != 0 && cnt_m[wa] > 0) nc[wa]--;
    end
    for (int p = 0; p < 2; p++) begin
      a = p == 1 ? a1 : a0;
      if (re[p]) begin
        e.v = a == 0 ? '0 : (we && wa == a) ? wv : mem_m[a];
        e.b = nc[a] != 0;
        q[p].push_back(e);
      end
    end
    if (we && wa != 0) mem_m[wa] = wv;
    cnt_m = nc;
  endtask
  task automatic idle();
    drive(0, 0, 0, 0, '0, 0, 2'b00, 0, 0);
  endtask
  task automatic do_reset();
    @(negedge clk);
    #2;
    rst_n = 0; rdEn = '0; issueEn = 0; issueRd = reg_t'(5); wif.en = 0; flush = 0;
    clear_model();
    #1;
    chk("rst rdVal0", rdVal[0], 0);
    chk("rst rdVal1", rdVal[1], 0);
    chk("rst rdBusy", 32'(rdBusy), 0);
    chk("rst issueReady r5", 32'(issueReady), 1);
    repeat (2) @(negedge clk);
    rst_n = 1;
  endtask
  initial forever begin
    bit [1:0] en_s;
    @(posedge clk);
    en_s = rdEn;
    #1;
    for (int p = 0; p < 2; p++) begin
      if (en_s[p] && rst_n) begin
        if (q[p].size() == 0) begin
          n_checks++; n_fail++;
          $display("FAIL port%0d read with no expectation queued at %0t", p, $time);
        end else last[p] = q[p].pop_front();
      end
      chk($sformatf("rdVal%0d", p), rdVal[p], last[p].v);
      chk($sformatf("rdBusy%0d", p), 32'(rdBusy[p]), 32'(last[p].b));
    end
  end
  initial begin
    rdEn = '0; rdAddr = '0; issueEn = 0; issueRd = '0; flush = 0;
    wif.en = 0; wif.addr = '0; wif.val = '0;
    clear_model();
    repeat (2) @(negedge clk);
    #1;
    chk("init rdVal0", rdVal[0], 0);
    chk("init rdBusy", 32'(rdBusy), 0);
    chk("init issueReady", 32'(issueReady), 1);
    rst_n = 1;
    drive(0, 0, 1, 3, 32'hDEADBEEF, 0, 2'b01, 3, 0);
    drive(0, 0, 1, 0, 32'h1234, 0, 2'b01, 0, 0);
    drive(0, 0, 0, 0, '0, 0, 2'b11, 0, 3);
    repeat (3) drive(1, 7, 0, 0, '0, 0, 2'b01, 7, 0);
    drive(1, 7, 0, 0, '0, 0, 2'b01, 7, 0);
    drive(1, 7, 1, 7, 32'h77, 0, 2'b11, 7, 7);
    drive(1, 7, 0, 0, '0, 0, 2'b01, 7, 0);
    repeat (3) drive(0, 0, 1, 7, 32'h78, 0, 2'b01, 7, 0);
    drive(1, 4, 0, 0, '0, 0, 2'b01, 4, 0);
    drive(1, 4, 1, 4, 32'h44, 0, 2'b01, 4, 0);
    drive(0, 0, 1, 4, 32'h45, 0, 2'b01, 4, 0);
    drive(1, 2, 0, 0, '0, 0, 2'b00, 0, 0);
    drive(1, 9, 0, 0, '0, 0, 2'b00, 0, 0);
    drive(1, 9, 0, 0, '0, 0, 2'b11, 9, 2);
    drive(1, 9, 0, 0, '0, 1, 2'b11, 9, 2);
    drive(0, 0, 1, 9, 32'h55, 0, 2'b01, 9, 0);
    drive(0, 0, 0, 0, '0, 0, 2'b11, 9, 2);
    drive(0, 0, 1, 1, 32'hAAAA5555, 0, 2'b11, 1, 1);
    drive(0, 0, 1, 1, 32'h1111, 0, 2'b01, 3, 1);
    drive(0, 0, 0, 0, '0, 0, 2'b10, 0, 7);
    drive(1, 5, 0, 0, '0, 0, 2'b11, 5, 3);
    drive(1, 5, 0, 0, '0, 0, 2'b11, 5, 3);
    do_reset();
    drive(0, 0, 0, 0, '0, 0, 2'b11, 5, 3);
    drive(0, 5, 0, 0, '0, 0, 2'b00, 0, 0);
    for (int n = 0; n < 600; n++) begin
      int w = $urandom_range(0, 7);
      drive($urandom_range(0, 3) != 0, $urandom_range(0, 7), $urandom_range(0, 2) == 0,
            ($urandom_range(0, 9) == 0) ? $urandom_range(0, 31) : w, $urandom,
            $urandom_range(0, 40) == 0, 2'($urandom_range(0, 3)),
            $urandom_range(0, 7), ($urandom_range(0, 4) == 0) ? w : $urandom_range(0, 31));
    end
    idle();
    idle();
    @(negedge clk);
    chk("q0 drained", q[0].size(), 0);
    chk("q1 drained", q[1].size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/register_file.md
# register_file

Architectural integer register file, the server end of `regfile_write_if` whose client is the write-back stage. It adds a per-register pending-write scoreboard. Decode/issue reads operands through synchronous read ports and uses the scoreboard to detect RAW hazards. Write-back retires results through `write0`.

## Interface
- `NUM_REGS`, default 32: architectural registers; register 0 is hardwired zero.
- `NUM_READ`, default 2: number of read ports.
- `CNT_W`, default 2: scoreboard counter width; at most 2^CNT_W-1 writes in flight per register.
- `clk`  in  1: clock; all state updates on the rising edge.
- `rst_n`  in  1: reset, asynchronous, active-low.
- `write0`  `regfile_write_if.Server`  -: `en`, `addr` (`reg_t`), `val` (`val_t`); write-back commit port.
- `rdEn`  in  `NUM_READ`: read request per port.
- `rdAddr`  in  `NUM_READ` x `reg_t`: read address per port.
- `rdVal`  out  `NUM_READ` x `val_t`: read data, valid one cycle after `rdEn`.
- `rdBusy`  out  `NUM_READ`: the register read has at least one pending write; valid alongside `rdVal`.
- `issueEn`  in  1: a uop writing `issueRd` is issued this cycle.
- `issueRd`  in  `reg_t`: destination of the issued uop.
- `issueReady`  out  1: an issue to `issueRd` would be accepted this cycle (combinational).
- `flush`  in  1: squash all in-flight uops and clear the scoreboard.

## Operation
- Storage is `NUM_REGS` x `val_t`. A write with `write0.en=1` and `addr!=0` updates `mem[addr]` at the clock edge. Writes to register 0 are dropped.
- Reads are synchronous. When `rdEn[i]=1`, the port registers `mem[rdAddr[i]]` and drives it on `rdVal[i]` in the next cycle. When `rdEn[i]=0`, `rdVal[i]` and `rdBusy[i]` hold their previous values.
- Write-first forwarding: if a write and a read target the same nonzero address in the same cycle, the read returns `write0.val`.
- Reading register 0 returns 0 with `rdBusy=0`.
- Scoreboard state is `cnt[r]`, `CNT_W` bits per register; `cnt[0]` is always 0.
  - `inc`: `issueEn & issueReady & issueRd!=0` increments `cnt[issueRd]`.
  - `dec`: `write0.en & write0.addr!=0 & cnt[addr]!=0` decrements `cnt[addr]`.
  - Same register, inc and dec in the same cycle: count unchanged.
  - A write to a register whose count is 0 does not underflow; the count stays 0. This covers stale writes after a flush.
- `issueReady` is 0 iff `issueRd!=0` and `cnt[issueRd]` is all-ones. The `dec` of the same cycle is not credited. A refused `issueEn` leaves all state unchanged.
- `flush=1`: all counters become 0 at the edge, overriding any inc or dec that cycle. Storage writes in the flush cycle still occur.
- `rdBusy[i]` is the next-state count of `rdAddr[i]` being nonzero, i.e. it includes the same cycle's inc, dec and flush.

## Timing
- Read latency is 1 cycle. Write-to-read visibility is the same cycle via forwarding.
- Issue-to-busy visibility: a read issued in the same cycle as the issue already reports busy.
- Reset (async assert, release synchronous to `clk`):
  - all `mem` = 0, all `cnt` = 0, `rdVal` = 0, `rdBusy` = 0;
  - `issueReady` = 1 combinationally from the cleared counts.
- Reset mid-operation discards all pending counts and register contents immediately. No output glitches to X.
- All inputs are sampled at the rising edge. There are no combinational paths from `write0` to any output.

## Structure
- `reg_t` and `val_t` come from the `Uop` package. Add `localparam REG_ZERO = '0` and a `sb_cnt_t` typedef (`CNT_W` bits) there.
- Sub-module `regfile_scoreboard` holds the counter array. It takes the inc/dec/flush inputs and outputs `issueReady` plus per-port next-state busy. The storage array and read ports stay in `register_file`.

## Test plan
- **Reset:** assert `rst_n=0` mid-stream with `cnt[5]=2` -> immediately `rdBusy=0` and `rdVal=0`; after release, read r5 -> 0, `rdBusy=0`, and `issueReady=1` for r5.
- **Write-first forwarding:** write r3=0xDEADBEEF with a same-cycle read of r3 -> next cycle `rdVal=0xDEADBEEF`. Write r0=0x1234 -> read r0 returns 0.
- **Saturation:** with `CNT_W=2`, issue r7 three times -> `issueReady=0`. A 4th issue is refused and count stays 3. Issue and write r7 in the same cycle with count 3 -> still refused, count becomes 2.
- **Simultaneous inc/dec:** with `cnt[4]=1`, issue and write r4 in the same cycle -> count stays 1 and a same-cycle read of r4 gives `rdBusy=1`; a following write of r4 -> `rdBusy=0`.
- **Flush:** issue r2, r9, r9, then flush -> all counts 0. A stale write r9=0x55 afterwards updates `mem[9]=0x55`, count stays 0 (no underflow), `rdBusy=0`.
- **Multi-port:** port0 reads r1 and port1 reads r1 while r1 is written -> both ports return the new value, and each port's hold behaviour is independent when only `rdEn[0]` is asserted.
